// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF    = 6;
   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DBG  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_CPU  = 2'd1,
      RD_DBG  = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/arb2_rr_pick.sv
// Two-way combinational pick between CPU (bit 0) and debug (bit 1).
// DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin with lock.
module arb2_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  arb_state_t last_owner,
   input  logic       lock_ok,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b01) begin
         gnt = 2'b01;
      end else if (req == 2'b10) begin
         gnt = 2'b10;
      end else if (req == 2'b11) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
         gnt = 2'b01;
`else
         // Contested: alternate owners, except a dbg burst may keep the port
         case (last_owner)
            ST_CPU:  gnt = 2'b10;
            ST_DBG:  gnt = lock_ok ? 2'b10 : 2'b01;
            default: gnt = 2'b01;
         endcase
`endif
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the debug/loader port.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority (lock and burst count ignored).
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_lock,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   rd_owner_t        rd_owner_q, rd_owner_d;
   logic [1:0]       gnt;
   logic             lock_ok;

   assign lock_ok = (state_q == ST_DBG) && dbg_req && dbg_lock
                    && (burst_cnt_q < CNT_W'(MAX_BURST));

   arb2_rr_pick u_pick (
      .req        ({dbg_req, cpu_req}),
      .last_owner (state_q),
      .lock_ok    (lock_ok),
      .gnt        (gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         rd_owner_q  <= RD_NONE;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rd_owner_q  <= rd_owner_d;
      end
   end

   // Next owner, burst length and pending read return
   always_comb begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
      rd_owner_d  = RD_NONE;
      if (gnt[0]) begin
         state_d = ST_CPU;
         if (!cpu_we) rd_owner_d = RD_CPU;
      end else if (gnt[1]) begin
         state_d     = ST_DBG;
         burst_cnt_d = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                          : burst_cnt_q + CNT_W'(1);
         if (!dbg_we) rd_owner_d = RD_DBG;
      end
   end

   // Grant, stall and RAM-side mux of the current winner
   always_comb begin
      cpu_gnt   = gnt[0];
      dbg_gnt   = gnt[1];
      cpu_stall = cpu_req & ~gnt[0];
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wren  = 1'b0;
      if (gnt[0]) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_wren  = cpu_we;
      end else if (gnt[1]) begin
         ram_addr  = dbg_addr;
         ram_wdata = dbg_wdata;
         ram_wren  = dbg_we;
      end
   end

   // Read data is ungated; rvalid marks which port owns it
   assign cpu_rvalid = (rd_owner_q == RD_CPU);
   assign dbg_rvalid = (rd_owner_q == RD_DBG);
   assign cpu_rdata  = ram_q;
   assign dbg_rdata  = ram_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized self-checking bench for dmem_port_arbiter against a behavioural model.
module tb_dmem_port_arbiter;

   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [5:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dbg_req = 1'b0, dbg_lock = 1'b0, dbg_we = 1'b0;
   logic [5:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [5:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_wren;
   logic [31:0] ram_q;

   dmem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM seen by the arbiter
   logic [31:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      ram_q <= ram_mem[ram_addr];
   end

   // Reference model: last owner (0 none, 1 cpu, 2 dbg), burst length, pending read
   int          last_own = 0;
   int          bcnt = 0;
   int          pend = 0;
   logic [31:0] pend_data = '0;
   logic [31:0] mdl_mem [64];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_winner(input logic c, input logic d, input logic l);
      if (!d) return c ? 1 : 0;
      if (!c) return 2;
`ifdef DMEM_ARB_CPU_PRIO_EN
      return (l === 1'bx) ? 0 : 1;
`else
      if (last_own == 1) return 2;
      if (last_own == 2 && l && bcnt < MAX_BURST) return 2;
      return 1;
`endif
   endfunction

   // One clock cycle: drive, check against the model, then advance the model
   task automatic cyc(input logic c, input logic cw, input logic [5:0] ca, input logic [31:0] cd,
                      input logic d, input logic dl, input logic dw, input logic [5:0] da,
                      input logic [31:0] dd);
      int w;
      @(negedge clk);
      cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = d; dbg_lock = dl; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      #1;
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pend == 2));
      if (pend == 1) chk("cpu_rdata", cpu_rdata, pend_data);
      if (pend == 2) chk("dbg_rdata", dbg_rdata, pend_data);
      chk("both_rvalid", 32'(cpu_rvalid & dbg_rvalid), 32'd0);
      w = pick_winner(c, d, dl);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(w == 1));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(w == 2));
      chk("cpu_stall", 32'(cpu_stall), 32'(c && w != 1));
      chk("ram_wren", 32'(ram_wren), 32'((w == 1 && cw) || (w == 2 && dw)));
      chk("ram_addr", 32'(ram_addr), (w == 1) ? 32'(ca) : (w == 2) ? 32'(da) : 32'd0);
      chk("ram_wdata", ram_wdata, (w == 1) ? cd : (w == 2) ? dd : 32'd0);
      pend = 0;
      if (w == 1) begin
         if (cw) mdl_mem[ca] = cd;
         else begin pend = 1; pend_data = mdl_mem[ca]; end
      end else if (w == 2) begin
         if (dw) mdl_mem[da] = dd;
         else begin pend = 2; pend_data = mdl_mem[da]; end
      end
      bcnt = (w == 2) ? ((bcnt < MAX_BURST) ? bcnt + 1 : bcnt) : 0;
      last_own = w;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
      last_own = 0; bcnt = 0; pend = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Preload every word so later reads have a known value
      for (int a = 0; a < 64; a++) cyc(1'b1, 1'b1, 6'(a), $urandom, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);

      // CPU-only write then read of 0xDEADBEEF
      cyc(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      cyc(1'b1, 1'b0, 6'd5, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      idle();
      chk("deadbeef_rdata", cpu_rdata, 32'hDEADBEEF);

      // Contested from idle without lock: alternates
      do_reset();
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 6'(10 + i), $urandom, 1'b1, 1'b0, 1'b1, 6'(20 + i), $urandom);

      // Locked debug burst against a held CPU request
      do_reset();
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b1, 6'(30 + i), $urandom, 1'b1, 1'b1, 1'b1, 6'(40 + i), $urandom);

      // Alternating-owner reads
      cyc(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1, 6'd1, 32'h11);
      cyc(1'b1, 1'b1, 6'd2, 32'h22, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      cyc(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 6'd1, 32'd0);
      cyc(1'b1, 1'b0, 6'd2, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      chk("alt_dbg_data", dbg_rdata, 32'h11);
      idle();
      chk("alt_cpu_data", cpu_rdata, 32'h22);

      // Reset with a debug read in flight, then a contested cycle
      cyc(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 1'b0, 6'd3, 32'd0);
      do_reset();
      cyc(1'b1, 1'b0, 6'd4, 32'd0, 1'b1, 1'b1, 1'b0, 6'd6, 32'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         else cyc($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  6'($urandom), $urandom);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
